// File: rtl/iob_int_arbiter.sv
// Interrupt-packet scheduler: arbitrates requesters, builds the two-flit interrupt packet, streams it on val/rdy NoC.
// Optional IOB_INT_ARB_RR_EN selects round-robin arbitration; default build is fixed priority (lowest index wins).
`ifndef NOC_DATA_WIDTH
`define NOC_DATA_WIDTH 64
`endif
`ifndef MSG_TYPE_INTERRUPT
`define MSG_TYPE_INTERRUPT 8'd33
`endif
`ifndef NOC_FBITS_L1
`define NOC_FBITS_L1 4'b0000
`endif
`ifndef MSG_DST_X
`define MSG_DST_X 49:42
`endif
`ifndef MSG_DST_Y
`define MSG_DST_Y 41:34
`endif

module iob_int_arbiter #(
   parameter int NUM_REQ = 16,
   parameter int X_TILES = 4,
   parameter int Y_TILES = 4
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic [NUM_REQ-1:0]           req_val,
   output logic [NUM_REQ-1:0]           req_rdy,
   input  logic [NUM_REQ*6-1:0]         req_tile_id,
   input  logic [NUM_REQ*9-1:0]         req_vec,
   output logic                         noc_out_val,
   input  logic                         noc_out_rdy,
   output logic [`NOC_DATA_WIDTH-1:0]   noc_out_data,
   output logic                         err_bad_dest,
   output logic [31:0]                  pkt_sent_cnt
);
   localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int DW = `NOC_DATA_WIDTH;
   localparam logic [5:0] XT = 6'(X_TILES);

   typedef enum logic [1:0] {IDLE, HDR, BODY} state_t;

   state_t                    state_q;
   logic [8:0]                vec_q;
   logic [31:0]               sent_cnt_q;
   logic [NUM_REQ-1:0][5:0]   tile_arr;
   logic [NUM_REQ-1:0][8:0]   vec_arr;
   logic                      gnt_any;
   logic [IW-1:0]             gnt_idx;
   logic [5:0]                sel_tile, dst_x, dst_y;
   logic                      tile_ok;
   logic [DW-1:0]             hdr;

   assign tile_arr     = req_tile_id;
   assign vec_arr      = req_vec;
   assign pkt_sent_cnt = sent_cnt_q;

`ifdef IOB_INT_ARB_RR_EN
   logic [IW-1:0] last_q;
   logic [IW-1:0] gidx_q;

   // Search starts one past the last grant and wraps.
   always_comb begin : arb
      int idx;
      gnt_any = 1'b0;
      gnt_idx = '0;
      idx     = 0;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx = (int'(last_q) + 1 + k) % NUM_REQ;
         if (!gnt_any && req_val[idx]) begin
            gnt_any = 1'b1;
            gnt_idx = IW'(idx);
         end
      end
   end
`else
   always_comb begin
      gnt_any = 1'b0;
      gnt_idx = '0;
      for (int k = NUM_REQ-1; k >= 0; k--) begin
         if (req_val[k]) begin
            gnt_any = 1'b1;
            gnt_idx = IW'(k);
         end
      end
   end
`endif

   assign sel_tile = tile_arr[gnt_idx];
   assign dst_x    = sel_tile % XT;
   assign dst_y    = sel_tile / XT;
   assign tile_ok  = int'(sel_tile) < X_TILES * Y_TILES;

   always_comb begin
      hdr = {14'b0, 5'b0, 3'b0, 8'b0, `NOC_FBITS_L1, 8'd1, `MSG_TYPE_INTERRUPT, 14'b0};
      hdr[`MSG_DST_X] = {2'b0, dst_x};
      hdr[`MSG_DST_Y] = {2'b0, dst_y};
   end

   // Grant is combinational so the requester sees acceptance in the request cycle.
   assign req_rdy = (rst_n && state_q == IDLE && gnt_any) ? (NUM_REQ'(1'b1) << gnt_idx) : '0;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         noc_out_val  <= 1'b0;
         noc_out_data <= '0;
         err_bad_dest <= 1'b0;
         sent_cnt_q   <= '0;
         vec_q        <= '0;
`ifdef IOB_INT_ARB_RR_EN
         last_q       <= IW'(NUM_REQ-1);
         gidx_q       <= '0;
`endif
      end else begin
         err_bad_dest <= 1'b0;
         case (state_q)
            IDLE: if (gnt_any) begin
               vec_q <= vec_arr[gnt_idx];
`ifdef IOB_INT_ARB_RR_EN
               gidx_q <= gnt_idx;
`endif
               if (tile_ok) begin
                  state_q      <= HDR;
                  noc_out_val  <= 1'b1;
                  noc_out_data <= hdr;
               end else begin
                  // Dropped request still moves the pointer so it cannot starve others.
                  err_bad_dest <= 1'b1;
`ifdef IOB_INT_ARB_RR_EN
                  last_q       <= gnt_idx;
`endif
               end
            end
            HDR: if (noc_out_rdy) begin
               state_q      <= BODY;
               noc_out_data <= DW'(vec_q);
            end
            BODY: if (noc_out_rdy) begin
               state_q      <= IDLE;
               noc_out_val  <= 1'b0;
               noc_out_data <= '0;
               sent_cnt_q   <= sent_cnt_q + 32'd1;
`ifdef IOB_INT_ARB_RR_EN
               last_q       <= gidx_q;
`endif
            end
            default: state_q <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_iob_int_arbiter.sv
// Scoreboard bench for iob_int_arbiter: stimulus pushes expected grants and flits, a negedge monitor pops and compares.
module tb_iob_int_arbiter;
   localparam int N = 16;

   logic                clk = 1'b0;
   logic                rst_n = 1'b0;
   logic [N-1:0]        req_val = '0;
   logic [N-1:0]        req_rdy;
   logic [N-1:0][5:0]   tile = '0;
   logic [N-1:0][8:0]   vec = '0;
   logic                noc_out_val;
   logic                noc_out_rdy = 1'b1;
   logic [63:0]         noc_out_data;
   logic                err_bad_dest;
   logic [31:0]         pkt_sent_cnt;

   int                  vectors = 0;
   int                  miscompares = 0;
   int                  hs_cnt = 0;
   logic [63:0]         flit_q[$];
   int                  gnt_q[$];
   logic                hold_prev = 1'b0;
   logic [63:0]         prev_data = '0;

   iob_int_arbiter #(.NUM_REQ(N), .X_TILES(4), .Y_TILES(4)) dut (
      .clk(clk), .rst_n(rst_n), .req_val(req_val), .req_rdy(req_rdy),
      .req_tile_id(tile), .req_vec(vec), .noc_out_val(noc_out_val),
      .noc_out_rdy(noc_out_rdy), .noc_out_data(noc_out_data),
      .err_bad_dest(err_bad_dest), .pkt_sent_cnt(pkt_sent_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic fail(input string name, input logic [63:0] act);
      vectors++;
      miscompares++;
      $display("FAIL %s: got %h, nothing expected", name, act);
   endtask

   function automatic logic [63:0] hdr(input int x, input int y);
      return (64'(x) << 42) | (64'(y) << 34) | (64'd1 << 22) | (64'd33 << 14);
   endfunction

   task automatic push_pkt(input int g, input int x, input int y, input logic [8:0] v);
      gnt_q.push_back(g);
      flit_q.push_back(hdr(x, y));
      flit_q.push_back(64'(v));
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_grant(input int idx);
      bit seen = 0;
      for (int c = 0; c < 200 && !seen; c++) begin
         @(negedge clk);
         if (req_rdy[idx]) seen = 1;
      end
      if (!seen) fail("grant_timeout", 64'(idx));
      tick();
   endtask

   task automatic wait_idle();
      bit done = 0;
      for (int c = 0; c < 200 && !done; c++) begin
         @(negedge clk);
         if (!noc_out_val && flit_q.size() == 0) done = 1;
      end
      if (!done) fail("drain_timeout", 64'(flit_q.size()));
      tick();
   endtask

   // Monitor: grants, flit handshakes, hold stability, idle data.
   always @(negedge clk) begin
      if (hold_prev) begin
         check("stable_val", 64'(noc_out_val), 64'd1);
         check("stable_data", noc_out_data, prev_data);
      end
      if (rst_n && |req_rdy) begin
         if (gnt_q.size() == 0) fail("unexpected_grant", 64'(req_rdy));
         else begin
            int g;
            logic [N-1:0] oh;
            g  = gnt_q.pop_front();
            oh = N'(1) << g;
            check("grant", 64'(req_rdy), 64'(oh));
         end
      end
      if (rst_n && noc_out_val && noc_out_rdy) begin
         hs_cnt++;
         if (flit_q.size() == 0) fail("unexpected_flit", noc_out_data);
         else check("flit", noc_out_data, flit_q.pop_front());
      end
      if (!noc_out_val) check("idle_data", noc_out_data, 64'd0);
      hold_prev = rst_n && noc_out_val && !noc_out_rdy;
      prev_data = noc_out_data;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      int h0;
      int order[4];
      // Reset values; a pending request must not be acknowledged during reset.
      req_val[0] = 1'b1;
      tick(); tick();
      @(negedge clk);
      check("rst_req_rdy", 64'(req_rdy), 64'd0);
      check("rst_val", 64'(noc_out_val), 64'd0);
      check("rst_data", noc_out_data, 64'd0);
      check("rst_err", 64'(err_bad_dest), 64'd0);
      check("rst_cnt", 64'(pkt_sent_cnt), 64'd0);
      req_val = '0;
      tick();
      rst_n = 1'b1;
      tick();

      // Single request: req 5, tile 6 -> X=2 Y=1.
      tile[5] = 6'd6; vec[5] = 9'h1A3;
      push_pkt(5, 2, 1, 9'h1A3);
      req_val[5] = 1'b1;
      wait_grant(5);
      req_val = '0;
      @(negedge clk);
      check("single_hdr_val", 64'(noc_out_val), 64'd1);
      check("single_hdr", noc_out_data, 64'h0000080400484000);
      @(negedge clk);
      check("single_body", noc_out_data, 64'h00000000000001A3);
      wait_idle();
      check("single_cnt", 64'(pkt_sent_cnt), 64'd1);

      // Back-pressure: 4 stalled HDR cycles, 3 stalled BODY cycles.
      tile[7] = 6'd13; vec[7] = 9'h0FF;
      push_pkt(7, 1, 3, 9'h0FF);
      noc_out_rdy = 1'b0;
      h0 = hs_cnt;
      req_val[7] = 1'b1;
      wait_grant(7);
      req_val = '0;
      repeat (4) tick();
      noc_out_rdy = 1'b1;
      tick();
      noc_out_rdy = 1'b0;
      repeat (3) tick();
      noc_out_rdy = 1'b1;
      tick();
      wait_idle();
      check("bp_handshakes", 64'(hs_cnt - h0), 64'd2);
      check("bp_cnt", 64'(pkt_sent_cnt), 64'd2);

      // Contention from a fresh reset.
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      @(negedge clk);
      check("rst2_cnt", 64'(pkt_sent_cnt), 64'd0);
      tick();
      tile[0] = 6'd1;  vec[0] = 9'h001;
      tile[3] = 6'd10; vec[3] = 9'h033;
      tile[15] = 6'd15; vec[15] = 9'h15F;
`ifdef IOB_INT_ARB_RR_EN
      order = '{0, 3, 15, 0};
`else
      order = '{0, 0, 0, 0};
`endif
      foreach (order[k]) begin
         case (order[k])
            0:       push_pkt(0, 1, 0, 9'h001);
            3:       push_pkt(3, 2, 2, 9'h033);
            default: push_pkt(15, 3, 3, 9'h15F);
         endcase
      end
      req_val[0] = 1'b1; req_val[3] = 1'b1; req_val[15] = 1'b1;
      foreach (order[k]) wait_grant(order[k]);
      req_val = '0;
      wait_idle();
      check("cont_cnt", 64'(pkt_sent_cnt), 64'd4);

      // Bad destination: tile 16 is outside the 4x4 mesh.
      tile[2] = 6'd16; vec[2] = 9'h0AA;
      gnt_q.push_back(2);
      req_val[2] = 1'b1;
      wait_grant(2);
      req_val = '0;
      @(negedge clk);
      check("bad_err_pulse", 64'(err_bad_dest), 64'd1);
      check("bad_no_val", 64'(noc_out_val), 64'd0);
      @(negedge clk);
      check("bad_err_clear", 64'(err_bad_dest), 64'd0);
      check("bad_no_val2", 64'(noc_out_val), 64'd0);
      check("bad_cnt", 64'(pkt_sent_cnt), 64'd4);
      tick();

      // Reset while BODY is stalled; held requests restart from index 0.
      tile[9] = 6'd3; vec[9] = 9'h005;
      tile[1] = 6'd4; vec[1] = 9'h011;
      gnt_q.push_back(9);
      flit_q.push_back(hdr(3, 0));
      req_val[9] = 1'b1;
      wait_grant(9);
      tick();
      noc_out_rdy = 1'b0;
      req_val[1] = 1'b1;
      push_pkt(1, 0, 1, 9'h011);
      push_pkt(9, 3, 0, 9'h005);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      noc_out_rdy = 1'b1;
      @(negedge clk);
      check("rstbody_val", 64'(noc_out_val), 64'd0);
      check("rstbody_data", noc_out_data, 64'd0);
      check("rstbody_cnt", 64'(pkt_sent_cnt), 64'd0);
      tick();
      req_val[1] = 1'b0;
      wait_grant(9);
      req_val = '0;
      wait_idle();
      check("rstbody_cnt2", 64'(pkt_sent_cnt), 64'd2);

      // Counter wrap via backdoor.
      @(negedge clk);
      dut.sent_cnt_q = 32'hFFFF_FFFF;
      tick();
      tile[4] = 6'd0; vec[4] = 9'h1FF;
      push_pkt(4, 0, 0, 9'h1FF);
      req_val[4] = 1'b1;
      wait_grant(4);
      req_val = '0;
      wait_idle();
      check("wrap_cnt", 64'(pkt_sent_cnt), 64'd0);

      check("flit_q_empty", 64'(flit_q.size()), 64'd0);
      check("gnt_q_empty", 64'(gnt_q.size()), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
